// File: rtl/slt_pkg.sv
// -----------------------------------------------------------------------------
// slt_pkg
//  Shared definitions for the iterative set-less-than unit.
//  - state_t       : two-state FSM encoding (ST_IDLE, ST_RUN)
//  - DEF_WIDTH     : default operand width
//  - DEF_CHUNK     : default number of bits compared per cycle
//  - num_chunks()  : number of CHUNK-bit slices in a WIDTH-bit operand
//  - idx_bits()    : width of the chunk index counter (never less than 1)
// -----------------------------------------------------------------------------
package slt_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CHUNK = 4;

   // Number of slices the operand is cut into.
   function automatic int num_chunks(input int width, input int chunk);
      return width / chunk;
   endfunction

   // A single-chunk configuration still needs a 1-bit index so the counter
   // and the mux select have a legal width.
   function automatic int idx_bits(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/slt_iter_chunk_compare.sv
// -----------------------------------------------------------------------------
// chunk_compare
//  Purely combinational unsigned magnitude compare of one operand slice.
//  Ports:
//   a, b  in   W  slice of operand A / operand B
//   lt    out  1  a < b
//   eq    out  1  a == b
//   gt    out  1  a > b
// -----------------------------------------------------------------------------
module chunk_compare #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         lt,
   output logic         eq,
   output logic         gt
);

   // Signed handling is done upstream by flipping the operand MSBs, so every
   // slice compare here is a plain unsigned one.
   assign lt = (a < b);
   assign eq = (a == b);
   assign gt = (a > b);

endmodule

// File: rtl/slt_iter.sv
// -----------------------------------------------------------------------------
// slt_iter
//  Multi-cycle set-less-than unit for the MIPS datapath. Operands are compared
//  CHUNK bits at a time starting from the MSB slice; signed (SLT) and unsigned
//  (SLTU) compares are both supported.
//  Parameters:
//   WIDTH       operand width, a multiple of CHUNK
//   CHUNK       bits compared per cycle
//   EARLY_EXIT  1: stop at the first differing slice, 0: always scan all slices
//  Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-high reset
//   start        in   1      request, only sampled while idle
//   a, b         in   WIDTH  operands, latched when start is accepted
//   signed_mode  in   1      1 = two's-complement compare, 0 = unsigned
//   busy         out  1      compare in progress
//   done         out  1      one-cycle pulse, outputs valid from this cycle
//   lt, eq, gt   out  1      A < B, A == B, A > B
//   result       out  WIDTH  zero-extended lt, the SLT writeback word
// -----------------------------------------------------------------------------
module slt_iter
   import slt_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int CHUNK      = DEF_CHUNK,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   output logic [WIDTH-1:0] result
);

   localparam int NCHUNK = num_chunks(WIDTH, CHUNK);
   localparam int IW     = idx_bits(NCHUNK);
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   // Flipping the sign bit maps two's-complement ordering onto unsigned
   // ordering, so one unsigned slice comparator serves both modes.
   localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IW-1:0]    idx;
   logic             decided;
   logic             dec_lt;
   logic             dec_gt;
   logic             finishing;

   logic [IW-1:0]    sel;
   logic [CHUNK-1:0] a_chunks [NCHUNK];
   logic [CHUNK-1:0] b_chunks [NCHUNK];
   logic [CHUNK-1:0] cur_a;
   logic [CHUNK-1:0] cur_b;
   logic             c_lt;
   logic             c_eq;
   logic             c_gt;
   logic             new_dec;
   logic             new_lt;
   logic             new_gt;
   logic             exit_now;

   // Slice views of the latched operands; slice 0 holds the LSBs.
   for (genvar i = 0; i < NCHUNK; i++) begin : g_slices
      assign a_chunks[i] = a_q[i*CHUNK +: CHUNK];
      assign b_chunks[i] = b_q[i*CHUNK +: CHUNK];
   end

   // idx counts scanned slices from the top, so the slice under test is the
   // mirror of idx. The mux feeds the single shared comparator.
   always_comb begin
      sel   = LAST_IDX - idx;
      cur_a = a_chunks[sel];
      cur_b = b_chunks[sel];
   end

   chunk_compare #(
      .W (CHUNK)
   ) u_chunk_compare (
      .a  (cur_a),
      .b  (cur_b),
      .lt (c_lt),
      .eq (c_eq),
      .gt (c_gt)
   );

   // The first differing slice (from the MSB) decides the outcome; later
   // slices are only looked at to keep the fixed-latency mode honest and may
   // never overwrite an earlier decision. Exiting is staged through
   // 'finishing' so the outputs are loaded from registered flags one edge
   // after the deciding compare.
   always_comb begin
      new_dec  = decided | ~c_eq;
      new_lt   = decided ? dec_lt : c_lt;
      new_gt   = decided ? dec_gt : c_gt;
      exit_now = (idx == LAST_IDX) || ((EARLY_EXIT != 0) && new_dec);
   end

   // Main FSM. IDLE accepts a request and latches operands; RUN walks the
   // slices and, once the scan is over, publishes lt/eq/gt/result together
   // with a single-cycle done pulse. Outputs are only ever written as a set,
   // so a consumer never sees a half-updated result. Reset drops any
   // in-flight compare without producing done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         idx       <= '0;
         decided   <= 1'b0;
         dec_lt    <= 1'b0;
         dec_gt    <= 1'b0;
         finishing <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         lt        <= 1'b0;
         eq        <= 1'b0;
         gt        <= 1'b0;
         result    <= '0;
      end else if (state == ST_IDLE) begin
         done <= 1'b0;
         if (start) begin
            a_q       <= signed_mode ? (a ^ SIGN_MASK) : a;
            b_q       <= signed_mode ? (b ^ SIGN_MASK) : b;
            idx       <= '0;
            decided   <= 1'b0;
            dec_lt    <= 1'b0;
            dec_gt    <= 1'b0;
            finishing <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_RUN;
         end
      end else begin
         if (finishing) begin
            lt        <= dec_lt;
            gt        <= dec_gt;
            eq        <= ~decided;
            result    <= {{(WIDTH-1){1'b0}}, dec_lt};
            done      <= 1'b1;
            busy      <= 1'b0;
            finishing <= 1'b0;
            idx       <= '0;
            state     <= ST_IDLE;
         end else begin
            decided <= new_dec;
            dec_lt  <= new_lt;
            dec_gt  <= new_gt;
            if (exit_now) begin
               finishing <= 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

endmodule
